cis_dvp_tx: RTL and testbench
=============================

// Module: cis_dvp_tx
// PURPOSE
//  Parallel camera (DVP) transmitter: drives PCLK/HREF/VSYNC/D[9:0] as a CIS sensor would.
//  Pixels come from an on-chip valid/ready stream, for example the ISP output or test patterns.
//  Sits in user_proj beside the CIS receiver, so the receiver can be looped back and a downstream
//  chip can be fed. All timing is derived from wb_clk_i; one pixel period is 2 clk.
// PARAMETERS
//  DATA_W    10   pixel width
//  H_ACTIVE  640  active pixels per line (>=1)
//  H_BLANK   160  blank pixel periods per line (>=1)
//  V_SYNC    3    lines with vsync high (>=1)
//  V_BP      17   back-porch lines (>=1)
//  V_ACTIVE  480  active lines (>=1)
//  V_FP      10   front-porch lines (>=1)
//  FIFO_AW   4    log2 of FIFO depth (depth 16)
// PORTS
//  wb_clk_i     in   1       system clock
//  wb_rst_i     in   1       asynchronous reset, active high
//  enable       in   1       level; start/continue frames
//  pix_valid    in   1       stream valid
//  pix_ready    out  1       stream ready; equals !fifo_full
//  pix_data     in   DATA_W  pixel
//  pix_sof      in   1       marks the first pixel of a frame
//  pclk_o       out  1       pixel clock = clk/2
//  href_o       out  1       line-valid
//  vsync_o      out  1       frame sync, active high
//  data_o       out  DATA_W  pixel data
//  busy         out  1       FSM not in IDLE
//  frame_done   out  1       1-clk pulse at end of front porch
//  underrun     out  1       sticky: active slot with FIFO empty
//  sync_err     out  1       sticky: sof misalignment
//  err_clr      in   1       clears underrun and sync_err (err_clr wins over a same-cycle set)
// BEHAVIOUR
//  Reset: every output is 0 (including pix_ready), the FIFO is empty and the FSM is in IDLE.
//  Phase toggle ph runs continuously and pclk_o = ph.
//  Pixel boundary = a clk edge with ph==1. At a boundary, href_o/vsync_o/data_o/counters update,
//  so they change as pclk falls and are stable at pclk rise.
//  FSM (advances only at boundaries): IDLE -> VS (when enable=1) -> VBP -> ACT -> VFP.
//   - Each line is H_ACTIVE+H_BLANK pixel periods. h_cnt wraps at the line end, v_cnt at the state end.
//   - VS: vsync_o=1 for V_SYNC lines, href_o=0.
//   - VBP and VFP: vsync_o=0, href_o=0.
//   - ACT: href_o=1 for the first H_ACTIVE slots of each line, then 0 for H_BLANK slots.
//   - At the end of VFP: frame_done pulses, then go to VS if enable=1, else IDLE.
//  enable deasserted mid-frame: the current frame completes. Frames are never truncated.
//  Active slot behaviour:
//   - FIFO not empty: pop one entry; data_o = entry.
//   - FIFO empty: data_o=0 and underrun is set.
//   - Blank slot: data_o=0.
//  sof check:
//   - The first active slot of a frame pops an entry with sof=0 -> sync_err.
//   - Any other active slot pops an entry with sof=1 -> sync_err.
//   - The data is output in both cases; there is no resync or discard.
//  Latency: enable high in IDLE -> vsync_o=1 at the next boundary (<=2 clk).
//   A pushed pixel reaches data_o at its active slot; there is no bypass path.
//  FIFO: entries are {sof,data}.
//   - A push accepted when pix_valid&&pix_ready.
//   - pix_ready comes from the registered count, so a push is rejected while full even if a pop
//     happens that cycle.
//   - Push and pop in the same cycle: count is unchanged and the pointers wrap modulo the depth.
//  Reset asserted mid-frame: all state clears asynchronously and the FIFO contents are discarded.
// STRUCTURE
//  Shared package (isp_pkg):
//   - FSM state enum: IDLE, VS, VBP, ACT, VFP.
//   - DVP_DATA_W constant.
//   - Counter width function clog2(H_ACTIVE+H_BLANK).
//  Sub-module dvp_tx_fifo (sync FIFO, DATA_W+1 wide, 2**FIFO_AW deep, full/empty/count).
//  Top holds ph, the FSM, h_cnt/v_cnt, the output registers and the sticky flags.
// TESTING (H_ACTIVE=4,H_BLANK=2,V_SYNC=1,V_BP=1,V_ACTIVE=2,V_FP=1,FIFO_AW=3; frame=30 px=60 clk)
//  1 Reset and idle:
//     reset, then enable=0 -> all outputs 0 and pclk_o toggles every clk.
//  2 One frame:
//     preload 8 px (sof on the 1st), data 1..8, then pulse enable.
//     -> vsync 6 px; href 2x4 px with data 1,2,3,4 / 5,6,7,8; frame_done 1 pulse;
//        busy drops; underrun=sync_err=0.
//  3 Underrun:
//     preload only 3 px.
//     -> 4th active slot data_o=0 and underrun=1.
//     err_clr -> underrun=0.
//  4 Backpressure:
//     push 9 px with no enable -> pix_ready=0 after 8 accepted and the 9th is held.
//     enable -> after the 1st pop, pix_ready=1 and the 9th is accepted.
//  5 sof errors:
//     frame whose first entry has sof=0 -> sync_err=1.
//     sof=1 on the 3rd pixel -> sync_err=1.
//  6 Disable and reset mid-frame:
//     enable low during ACT -> frame completes, then IDLE.
//     wb_rst_i mid-ACT -> outputs 0 asynchronously and FIFO empty.

Source files
------------

// File: rtl/isp_pkg.sv
// isp_pkg: shared DVP definitions (FSM state encoding, pixel width, counter width helper)
package isp_pkg;
    localparam int DVP_DATA_W = 10;
    typedef enum logic [2:0] {IDLE, VS, VBP, ACT, VFP} dvp_state_e;
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction
endpackage

// File: rtl/dvp_tx_fifo.sv
// dvp_tx_fifo: synchronous FIFO holding {sof,data} entries for the DVP transmitter
//   clk_i/rst_i  clock, asynchronous active-high reset
//   push_i       write wdata_i (caller guarantees !full_o)
//   pop_i        advance read pointer (caller guarantees !empty_o)
//   rdata_o      head entry, valid while !empty_o
//   full_o       registered count equals depth
//   empty_o      registered count is zero
module dvp_tx_fifo import isp_pkg::*; #(
    parameter int W  = 11,
    parameter int AW = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int DEPTH = 1 << AW;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q, count_d;
    always_comb begin
        count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        rdata_o = mem_q[rd_q];
        full_o  = count_q == (AW+1)'(DEPTH);
        empty_o = count_q == '0;
    end
    always_ff @(posedge clk_i)
        if (push_i) mem_q[wr_q] <= wdata_i;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_q + AW'(push_i);
            rd_q    <= rd_q + AW'(pop_i);
            count_q <= count_d;
        end
endmodule

// File: rtl/cis_dvp_tx.sv
// cis_dvp_tx: DVP camera transmitter producing PCLK/HREF/VSYNC/D from a valid/ready pixel stream
//   wb_clk_i/wb_rst_i   clock, asynchronous active-high reset
//   enable              start/continue frames (sampled in IDLE and at end of front porch)
//   pix_valid/ready     stream handshake; pix_ready = !full (0 in reset)
//   pix_data/pix_sof    pixel and first-of-frame marker
//   pclk_o              clk/2; href_o/vsync_o/data_o change as pclk falls
//   busy                FSM not idle
//   frame_done          1-clk pulse leaving the front porch
//   underrun/sync_err   sticky error flags, cleared by err_clr
module cis_dvp_tx import isp_pkg::*; #(
    parameter int DATA_W   = DVP_DATA_W,
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int FIFO_AW  = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              enable,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              pix_sof,
    output logic              pclk_o,
    output logic              href_o,
    output logic              vsync_o,
    output logic [DATA_W-1:0] data_o,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun,
    output logic              sync_err,
    input  logic              err_clr
);
    localparam int H_TOT = H_ACTIVE + H_BLANK;
    localparam int HW    = clog2(H_TOT);
    localparam int VW    = clog2(V_SYNC + V_BP + V_ACTIVE + V_FP);
    dvp_state_e        state_q, state_d;
    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d, v_last;
    logic              ph_q, rdy_q, href_q, vsync_q, done_q, under_q, serr_q;
    logic [DATA_W-1:0] data_q;
    logic              line_end, st_end, act_d, first_d, pop, full, empty;
    logic [DATA_W:0]   rdata;
    dvp_tx_fifo #(.W(DATA_W + 1), .AW(FIFO_AW)) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (pix_valid && pix_ready),
        .pop_i   (pop),
        .wdata_i ({pix_sof, pix_data}),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty)
    );
    // Everything below describes the slot that starts at the next boundary
    always_comb begin
        v_last   = state_q == VS  ? VW'(V_SYNC - 1) :
                   state_q == VBP ? VW'(V_BP - 1) :
                   state_q == ACT ? VW'(V_ACTIVE - 1) : VW'(V_FP - 1);
        line_end = h_q == HW'(H_TOT - 1);
        st_end   = line_end && v_q == v_last;
        h_d      = (state_q == IDLE || line_end) ? '0 : h_q + 1'b1;
        v_d      = (state_q == IDLE || st_end) ? '0 : line_end ? v_q + 1'b1 : v_q;
        state_d  = state_q == IDLE ? (enable ? VS : IDLE) :
                   !st_end         ? state_q :
                   state_q == VS   ? VBP :
                   state_q == VBP  ? ACT :
                   state_q == ACT  ? VFP : (enable ? VS : IDLE);
        act_d    = state_d == ACT && h_d < HW'(H_ACTIVE);
        first_d  = act_d && v_d == '0 && h_d == '0;
        pop      = ph_q && act_d && !empty;
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            ph_q    <= 1'b0;
            rdy_q   <= 1'b0;
            state_q <= IDLE;
            h_q     <= '0;
            v_q     <= '0;
            href_q  <= 1'b0;
            vsync_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            under_q <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            ph_q    <= !ph_q;
            rdy_q   <= 1'b1;
            done_q  <= ph_q && state_q == VFP && st_end;
            if (ph_q) begin
                state_q <= state_d;
                h_q     <= h_d;
                v_q     <= v_d;
                href_q  <= act_d;
                vsync_q <= state_d == VS;
                data_q  <= pop ? rdata[DATA_W-1:0] : '0;
            end
            under_q <= !err_clr && (under_q || (ph_q && act_d && empty));
            serr_q  <= !err_clr && (serr_q || (pop && rdata[DATA_W] != first_d));
        end
    // rdy_q keeps pix_ready low while in reset; full comes from the registered count
    assign pix_ready  = rdy_q && !full;
    assign pclk_o     = ph_q;
    assign href_o     = href_q;
    assign vsync_o    = vsync_q;
    assign data_o     = data_q;
    assign busy       = state_q != IDLE;
    assign frame_done = done_q;
    assign underrun   = under_q;
    assign sync_err   = serr_q;
endmodule

// File: tb/tb_cis_dvp_tx.sv
// tb_cis_dvp_tx: scoreboard bench comparing DVP slots against a frame-geometry model
module tb_cis_dvp_tx;
    localparam int DW = 10, HA = 4, HB = 2, VSY = 1, VBPL = 1, VA = 2, VFPL = 1, AW = 3;
    localparam int HT = HA + HB;
    localparam int FRAME = HT * (VSY + VBPL + VA + VFPL);
    localparam int ACT0 = HT * (VSY + VBPL);
    localparam int ACT1 = ACT0 + HT * VA;
    logic clk = 0, rst = 1, enable = 0, pix_valid = 0, pix_sof = 0, err_clr = 0;
    logic [DW-1:0] pix_data = '0;
    logic pix_ready, pclk_o, href_o, vsync_o, busy, frame_done, underrun, sync_err;
    logic [DW-1:0] data_o;
    int total = 0, bad = 0, done_cnt = 0, slot = 0;
    logic [DW:0] exp_q [$];
    logic exp_under = 0, exp_sync = 0, in_frame = 0, ev, eh;
    logic [DW:0] e;

    cis_dvp_tx #(.DATA_W(DW), .H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VSY), .V_BP(VBPL),
                 .V_ACTIVE(VA), .V_FP(VFPL), .FIFO_AW(AW)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .enable(enable), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_data(pix_data), .pix_sof(pix_sof), .pclk_o(pclk_o),
        .href_o(href_o), .vsync_o(vsync_o), .data_o(data_o), .busy(busy),
        .frame_done(frame_done), .underrun(underrun), .sync_err(sync_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, a, x);
        end
    endtask

    // Monitor: one sample per pixel slot while pclk is high; the model derives
    // vsync/href from the slot index and pops the expected pixel on active slots.
    always @(negedge clk) begin
        if (rst) begin
            in_frame = 0;
            exp_q.delete();
            exp_under = 0;
            exp_sync = 0;
        end else begin
            if (frame_done) done_cnt++;
            if (pclk_o) begin
                if (!in_frame && vsync_o) begin
                    in_frame = 1;
                    slot = 0;
                end
                if (in_frame) begin
                    ev = slot < HT * VSY;
                    eh = slot >= ACT0 && slot < ACT1 && (slot % HT) < HA;
                    e = '0;
                    if (eh) begin
                        if (exp_q.size() == 0) exp_under = 1;
                        else begin
                            e = exp_q.pop_front();
                            if (e[DW] != (slot == ACT0)) exp_sync = 1;
                        end
                    end
                    chk($sformatf("slot%0d", slot), {vsync_o, href_o, data_o}, {ev, eh, e[DW-1:0]});
                    slot++;
                    if (slot == FRAME) in_frame = 0;
                end else
                    chk("idle_line", {vsync_o, href_o, data_o}, '0);
            end
        end
    end

    task automatic push_px(input logic s, input logic [DW-1:0] d);
        logic ok;
        ok = 0;
        pix_valid = 1;
        pix_sof = s;
        pix_data = d;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = pix_ready;
            @(posedge clk);
            if (ok) exp_q.push_back({s, d});
        end
        #1;
        pix_valid = 0;
        pix_sof = 0;
        chk("push_accept", ok, 1);
    endtask

    task automatic preload(input int n, input int base, input logic [15:0] mask);
        for (int i = 0; i < n; i++) push_px(mask[i], DW'(base + i));
    endtask

    task automatic start_frame();
        int n;
        n = 0;
        enable = 1;
        while (!vsync_o && n < 4) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("vsync_latency", vsync_o && n <= 2, 1);
        enable = 0;
    endtask

    task automatic wait_idle(input int d0);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("busy_drop", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("frame_done_cnt", done_cnt - d0, 1);
    endtask

    task automatic wait_href();
        int n;
        n = 0;
        while (!href_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("href_seen", href_o, 1);
    endtask

    task automatic chk_flags(input string n);
        chk({n, "_underrun"}, underrun, exp_under);
        chk({n, "_sync_err"}, sync_err, exp_sync);
    endtask

    task automatic clear_err();
        err_clr = 1;
        @(posedge clk);
        #1;
        err_clr = 0;
        exp_under = 0;
        exp_sync = 0;
        chk("err_clr", {underrun, sync_err}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic p;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {pix_ready, pclk_o, href_o, vsync_o, data_o, busy, frame_done, underrun, sync_err}, 0);
        @(posedge clk);
        #1;
        rst = 0;
        // 1: idle with enable low
        for (int i = 0; i < 6; i++) begin
            p = pclk_o;
            @(posedge clk);
            #1;
            chk("pclk_toggle", pclk_o, !p);
        end
        chk("idle_outs", {href_o, vsync_o, data_o, busy, frame_done, underrun, sync_err}, 0);
        chk("idle_ready", pix_ready, 1);
        // 2: one full frame
        preload(8, 1, 16'h0001);
        d0 = done_cnt;
        start_frame();
        wait_idle(d0);
        chk_flags("frame");
        // 3: underrun
        preload(3, 11, 16'h0001);
        d0 = done_cnt;
        start_frame();
        wait_idle(d0);
        chk("underrun_set", underrun, 1);
        chk_flags("under");
        clear_err();
        // 4: backpressure
        preload(8, 1, 16'h0001);
        @(negedge clk);
        chk("ready_full", pix_ready, 0);
        @(posedge clk);
        #1;
        d0 = done_cnt;
        fork
            push_px(1'b0, DW'(9));
            begin
                start_frame();
                wait_idle(d0);
            end
        join
        chk("held_left", exp_q.size(), 1);
        chk_flags("bp");
        // 5a: leftover entry (sof=0) starts the frame
        preload(7, 20, 16'h0000);
        d0 = done_cnt;
        start_frame();
        wait_idle(d0);
        chk("sync_first", sync_err, 1);
        chk_flags("sof_a");
        clear_err();
        // 5b: sof on the third pixel
        preload(8, 30, 16'h0005);
        d0 = done_cnt;
        start_frame();
        wait_idle(d0);
        chk("sync_mid", sync_err, 1);
        chk_flags("sof_b");
        clear_err();
        // 6a: enable dropped during ACT
        preload(8, 40, 16'h0001);
        d0 = done_cnt;
        enable = 1;
        wait_href();
        enable = 0;
        wait_idle(d0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("stay_idle", {vsync_o, busy}, 0);
        end
        chk_flags("dis");
        // 6b: reset mid-ACT, then a frame proves the FIFO was emptied
        preload(8, 50, 16'h0001);
        start_frame();
        wait_href();
        repeat (3) @(posedge clk);
        #3;
        rst = 1;
        #1;
        chk("rst_async", {href_o, vsync_o, data_o, busy, pix_ready, underrun, sync_err, frame_done}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        exp_q.delete();
        d0 = done_cnt;
        start_frame();
        wait_idle(d0);
        chk("rst_fifo_empty", underrun, 1);
        chk_flags("rst");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
